// File: rtl/jpeg_block_pingpong_ram.sv
// jpeg_block_pingpong_ram
//
// Double-buffered block RAM between a JPEG producer stage (dequantiser or
// IDCT pass 1) and a consumer stage (IDCT pass 2 or output reorder). The
// producer fills one bank in any address order and commits it; the consumer
// reads the other bank and releases it. Bank ownership is tracked per bank,
// so block N+1 loads while block N drains.
//
// Parameters:
//   WIDTH   data word width
//   ADDR_W  address width, each bank holds 2**ADDR_W words
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   wr_i             write strobe into the current write bank
//   wr_addr_i        write address
//   wr_data_i        write data
//   wr_commit_i      hand the current write bank to the consumer
//   wr_ready_o       current write bank is free (writes/commit accepted)
//   rd_valid_o       current read bank holds a committed block
//   rd_i             read strobe from the current read bank
//   rd_addr_i        read address
//   rd_release_i     return the current read bank to the producer
//   rd_data_o        registered read data
//   rd_data_valid_o  rd_data_o valid this cycle
//   level_o          number of committed, unreleased banks (0..2)
//
// Build option:
//   JPEG_BLOCK_RAM_ZERO_FILL_EN  per-bank written-mask; reads of addresses
//                                not written in the current block return 0.

module jpeg_block_pingpong_ram #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              wr_commit_i,
    output logic              wr_ready_o,
    output logic              rd_valid_o,
    input  logic              rd_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              rd_release_i,
    output logic [WIDTH-1:0]  rd_data_o,
    output logic              rd_data_valid_o,
    output logic [1:0]        level_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [2][DEPTH];

    logic       wr_bank_q;
    logic       rd_bank_q;
    logic [1:0] full_q;
    logic [1:0] full_d;

    logic wr_acc;
    logic commit_acc;
    logic rd_acc;
    logic release_acc;

    assign wr_ready_o  = ~full_q[wr_bank_q];
    assign rd_valid_o  = full_q[rd_bank_q];
    assign level_o     = {1'b0, full_q[0]} + {1'b0, full_q[1]};

    assign wr_acc      = wr_i & wr_ready_o;
    assign commit_acc  = wr_commit_i & wr_ready_o;
    assign rd_acc      = rd_i & rd_valid_o;
    assign release_acc = rd_release_i & rd_valid_o;

    // A commit needs an empty write bank and a release needs a full read
    // bank, so when both are accepted they always address different banks.
    always_comb begin
        full_d = full_q;
        if (commit_acc) full_d[wr_bank_q] = 1'b1;
        if (release_acc) full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (commit_acc) wr_bank_q <= ~wr_bank_q;
            if (release_acc) rd_bank_q <= ~rd_bank_q;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_acc) mem[wr_bank_q][wr_addr_i] <= wr_data_i;
    end

`ifdef JPEG_BLOCK_RAM_ZERO_FILL_EN
    logic [DEPTH-1:0] mask_q [2];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q[0] <= '0;
            mask_q[1] <= '0;
        end else begin
            if (release_acc) mask_q[rd_bank_q] <= '0;
            if (wr_acc) mask_q[wr_bank_q][wr_addr_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_o       <= '0;
            rd_data_valid_o <= 1'b0;
        end else begin
            rd_data_valid_o <= rd_acc;
            if (rd_acc) begin
                rd_data_o <= mask_q[rd_bank_q][rd_addr_i] ? mem[rd_bank_q][rd_addr_i]
                                                          : '0;
            end
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_o       <= '0;
            rd_data_valid_o <= 1'b0;
        end else begin
            rd_data_valid_o <= rd_acc;
            if (rd_acc) rd_data_o <= mem[rd_bank_q][rd_addr_i];
        end
    end
`endif

endmodule

// File: doc/jpeg_block_pingpong_ram.md
# jpeg_block_pingpong_ram

Double-buffered block RAM for the JPEG decode pipeline: two banks of `DEPTH` words of `WIDTH` bits each, with explicit bank hand-over between a producer (dequantiser or IDCT pass 1) and a consumer (IDCT pass 2 or output reorder). The producer fills one bank in any address order while the consumer reads the other, so block N+1 loads while block N drains. It is the parametrised, flow-controlled successor to the fixed 64x16 IDCT transpose RAM, and adds optional zero-fill of unwritten coefficients for sparse blocks.

## Interface
- `WIDTH`, 16, data word width in bits.
- `ADDR_W`, 6, address width; each bank holds `DEPTH = 2**ADDR_W` words.
- `clk_i` input 1 — single clock, all logic on the rising edge.
- `rst_i` input 1 — synchronous, active-high reset.
- `wr_i` input 1 — write strobe into the current write bank.
- `wr_addr_i` input ADDR_W — write address.
- `wr_data_i` input WIDTH — write data.
- `wr_commit_i` input 1 — hand the current write bank to the consumer.
- `wr_ready_o` output 1 — current write bank is free; writes and commit are accepted only when high.
- `rd_valid_o` output 1 — current read bank holds a committed block.
- `rd_i` input 1 — read strobe from the current read bank.
- `rd_addr_i` input ADDR_W — read address.
- `rd_release_i` input 1 — return the current read bank to the producer.
- `rd_data_o` output WIDTH — read data, registered.
- `rd_data_valid_o` output 1 — `rd_data_o` valid this cycle.
- `level_o` output 2 — number of committed, unreleased banks (0..2).

## Operation
- State: `wr_bank_q`, `rd_bank_q` (1 bit each), `full_q[1:0]` per-bank ownership flag.
- `wr_ready_o = !full_q[wr_bank_q]`; `rd_valid_o = full_q[rd_bank_q]`; `level_o = full_q[0] + full_q[1]`.
- Write accepted when `wr_i && wr_ready_o`: bank `wr_bank_q` at `wr_addr_i` takes `wr_data_i`. Writes with `wr_ready_o` low are dropped; no state changes.
- Commit accepted when `wr_commit_i && wr_ready_o`: `full_q[wr_bank_q]` sets, `wr_bank_q` toggles. Commit with `wr_ready_o` low is ignored.
- Write and commit in the same cycle: the write lands in the committing bank.
- Read accepted when `rd_i && rd_valid_o`: bank `rd_bank_q` at `rd_addr_i` is captured into `rd_data_o`. Reads with `rd_valid_o` low produce no data valid; `rd_data_o` holds.
- Release accepted when `rd_release_i && rd_valid_o`: `full_q[rd_bank_q]` clears, `rd_bank_q` toggles. Release with `rd_valid_o` low is ignored.
- Read and release in the same cycle: the read returns data from the bank being released.
- Commit and release in the same cycle always target different banks; both take effect.
- Commit into a bank the consumer is releasing in the same cycle cannot occur: `wr_ready_o` is low for a full bank.
- Producer and consumer never access the same bank, so there is no read/write collision.
- Reset: `full_q = 0`, both pointers 0, `rd_data_o = 0`, `rd_data_valid_o = 0`, `level_o = 0`, `wr_ready_o = 1`, `rd_valid_o = 0`. RAM array contents are not reset.
- Reset mid-block discards both banks. Data in flight is lost, and no `rd_data_valid_o` pulse follows reset.

## Timing
- Write: 1 cycle. Data is readable by the consumer only after the commit.
- Commit to `rd_valid_o` high: 1 cycle when the read bank is the committed bank.
- Read latency: 1 cycle. `rd_data_valid_o` pulses in the cycle after an accepted `rd_i`. Back-to-back reads give one word per cycle.
- Release to `wr_ready_o` high: 1 cycle when the producer is stalled on that bank.
- Sustained throughput: one write and one read per cycle concurrently.

## Configuration
- `JPEG_BLOCK_RAM_ZERO_FILL_EN` defined:
  - Each bank carries a `DEPTH`-bit written-mask.
  - An accepted write sets the bit.
  - An accepted release of the bank, or reset, clears the whole mask.
  - An accepted read of an address whose bit is clear returns 0.
  - Lets the producer write only non-zero coefficients.
- Macro undefined:
  - No mask.
  - Reads return stored contents; unwritten addresses return stale data from the bank's previous block, or X after reset.

## Test plan
- Reset, fill bank 0 with addr k -> data k+0x100 for k=0..63, commit -> `wr_ready_o=1` (bank 1 free), `rd_valid_o=1`, `level_o=1`; read addr 5 -> next cycle `rd_data_o=0x105`, `rd_data_valid_o=1`.
- Commit two blocks without release -> `level_o=2`, `wr_ready_o=0`. A third-block write of 0xDEAD is dropped, and both banks read back intact. Release once -> `wr_ready_o=1` next cycle.
- Same-cycle write (addr 63, 0x7FF) plus commit -> reading addr 63 of that bank returns 0x7FF.
- Same-cycle read of addr 0 plus release on bank 0 -> `rd_data_o` equals bank 0 data; the next read comes from bank 1, or `rd_valid_o=0` if bank 1 is empty.
- Zero-fill on: write only addr 0=0x0040 and addr 9=0xFFC0, commit, read all 64 -> zeros except those two. Release and refill the same bank with addr 1 only -> addr 0 now reads 0.
- Assert `rst_i` mid-fill with one bank committed -> next cycle `level_o=0`, `rd_valid_o=0`, `wr_ready_o=1`, `rd_data_valid_o=0`.
